// File: rtl/uart_pkg.sv
// UART shared definitions: serializer FSM states and line constants.
// Used by both the TX and RX paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and an up/down occupancy count.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, count, full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter with a fixed clocks-per-bit rate.
// Ports: clk, rst, wr_valid/wr_data/wr_ready, tx, tx_busy, fifo_count/full/empty, overflow.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             overflow
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state, state_n;
    logic [BW-1:0]             baud_cnt, baud_n;
    logic [2:0]                bit_idx, bit_idx_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n;
    logic                      tx_n;
    logic                      push;
    logic                      pop;
    logic                      bit_end;
    logic [7:0]                fifo_dout;

    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready;
    assign tx_busy  = (state != IDLE);
    assign bit_end  = (baud_cnt == BAUD_MAX);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wr_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= UART_IDLE_LEVEL;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx       <= tx_n;
            if (wr_valid && !wr_ready) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = bit_end ? '0 : baud_cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_idx == LAST_BIT)
                        state_n = STOP;
                    else
                        bit_idx_n = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from the next state so the line level
        // lines up with the state that owns it.
        tx_n = UART_IDLE_LEVEL;
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

FIFO-buffered UART transmitter, the transmit-direction counterpart of the receive path in `tt_uart_fifo`. Bytes from the parallel side are queued in a small synchronous FIFO. They are serialized onto `tx` as 8N1 frames (one start bit, eight data bits LSB first, one stop bit) at a fixed integer clocks-per-bit rate. In the top level, `tx` drives the UART TX line on `uio_out`, with its `uio_oe` bit tied high.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: `clk` cycles per bit (100 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of two, ≥ 2.
- `CNT_W`, default `$clog2(FIFO_DEPTH)+1`: width of `fifo_count`.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous active-high reset.
- `wr_valid` input 1: write request.
- `wr_data` input 8: byte to queue.
- `wr_ready` output 1: FIFO can accept; combinational `!fifo_full`.
- `tx` output 1: serial output, idle high; registered.
- `tx_busy` output 1: high whenever the FSM is not in IDLE.
- `fifo_count` output CNT_W: number of bytes queued, 0..FIFO_DEPTH.
- `fifo_full` output 1: `fifo_count == FIFO_DEPTH`.
- `fifo_empty` output 1: `fifo_count == 0`.
- `overflow` output 1: sticky; set by any `wr_valid` while `!wr_ready`; cleared only by `rst`.

## Operation
- Reset values:
  - `tx`=1, `tx_busy`=0, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `wr_ready`=1, `overflow`=0.
  - FSM in IDLE; pointers, bit counter and baud counter all 0.
- Push occurs when `wr_valid && wr_ready`. A refused write leaves FIFO contents unchanged and sets `overflow`.
- FSM states and transitions:
  - IDLE: `tx`=1. If `!fifo_empty`, pop the head into a shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7 go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if `!fifo_empty`, pop and go to START (no idle gap); otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps. It resets to 0 on every state change.
- Pointers wrap modulo FIFO_DEPTH. `fifo_count` is an up/down counter:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on simultaneous push and pop.
- Boundary conditions:
  - Full, with a pop in the same cycle: the write is still refused because `wr_ready` is low. It sets `overflow`.
  - Empty, with a push: no fall-through. The pop happens at the earliest on the next cycle.
  - `rst` mid-frame: the frame is aborted. `tx` goes to 1 on the next edge and the FIFO is flushed.

## Timing
- Push in cycle N → `fifo_count` and flags update at the edge ending cycle N.
- FIFO non-empty while IDLE in cycle N → pop in cycle N, `tx` falls from cycle N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Consecutive queued bytes are sent back-to-back: the next start bit follows the stop bit's last cycle directly.
- Byte written into an empty FIFO while IDLE in cycle N → start bit from cycle N+2.
- `tx_busy` rises with the first start-bit cycle. It falls on the first IDLE cycle.

## Structure
- Package `uart_pkg`:
  - FSM state enum `tx_state_t` {IDLE, START, DATA, STOP}.
  - Constants `UART_DATA_BITS`=8, `UART_IDLE_LEVEL`=1'b1.
  - Shared with the RX path.
- Sub-module `sync_fifo`:
  - Parameters: width 8, depth FIFO_DEPTH.
  - Ports: push/pop, count/full/empty.
  - Registered storage; `dout` is valid at the head whenever not empty.
- Serializer FSM and baud counter live in `uart_tx_fifo`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset check: assert `rst` for 2 cycles → `tx`=1, `fifo_empty`=1, `wr_ready`=1, `overflow`=0, `tx_busy`=0.
- Single byte: write 0xA5 → `tx` low from 2 cycles after the write. Sampled at bit centres the line reads 0, then 1,0,1,0,0,1,0,1, then 1. Total 40 cycles, after which `tx_busy`=0.
- Back-to-back: write 0x00, 0xFF, 0x55 in consecutive cycles → three frames in 120 contiguous cycles with no idle gap. `fifo_count` sequence after the writes: 1, 1, 2, then it decrements at each frame start.
- Overflow: while the first frame is in flight, write 5 more bytes (FIFO holds 4 after one pop) → the 5th is refused with `wr_ready`=0 and `overflow`=1. Only 4 further frames are emitted.
- Full with simultaneous pop: hold the FIFO full and assert `wr_valid` on the cycle a STOP→START pop occurs → write refused, `fifo_count` goes 4→3, `overflow`=1.
- Mid-frame reset: assert `rst` during DATA bit 3 of 0x0F with 2 bytes queued → `tx`=1 on the next edge, `fifo_count`=0, and no further frames are sent.
